id_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the decode stage. It tracks every in-flight register write by producer latency, so the stage no longer needs one hard-wired comparator per pipeline stage. Each cycle it reports whether the instruction in ID must stall, and for each source operand whether the value must come from the bypass network rather than the register file. It sits between ID and the stall controller. Its stall output ORs into the existing ID stall request.

---
 rtl/id_scoreboard_if.sv | 36 +++
 rtl/id_scoreboard.sv | 113 +++++++++++
 tb/tb_id_scoreboard.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// Bundle between the decode stage and the register-hazard scoreboard:
// issue/read/retire requests in, stall and bypass decisions out.
interface id_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) ();
    localparam int NREGS = 1 << AW;

    logic              rdy;
    logic              issue_valid_i;
    logic              issue_wreg_i;
    logic [AW-1:0]     issue_rd_i;
    logic              issue_is_load_i;
    logic [NRD-1:0]    rs_read_i;
    logic [NRD*AW-1:0] rs_addr_i;
    logic              wb_valid_i;
    logic [AW-1:0]     wb_rd_i;
    logic              stall_o;
    logic [NRD-1:0]    fwd_hit_o;
    logic [NREGS-1:0]  busy_o;
    logic [XLEN-1:0]   stall_cnt_o;
    logic              err_o;

    modport master (
        output rdy, issue_valid_i, issue_wreg_i, issue_rd_i, issue_is_load_i,
               rs_read_i, rs_addr_i, wb_valid_i, wb_rd_i,
        input  stall_o, fwd_hit_o, busy_o, stall_cnt_o, err_o
    );

    modport slave (
        input  rdy, issue_valid_i, issue_wreg_i, issue_rd_i, issue_is_load_i,
               rs_read_i, rs_addr_i, wb_valid_i, wb_rd_i,
        output stall_o, fwd_hit_o, busy_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage register hazard scoreboard: counts outstanding writes per
// register and the cycles until the newest one can be bypassed.
module id_scoreboard #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ALU_LAT = 0,
    parameter int LD_LAT  = 2,
    parameter int CW      = 2,
    parameter int IW      = 2
) (
    input  logic           clk,
    input  logic           rst,
    id_scoreboard_if.slave sb
);
    localparam int            NREGS   = 1 << AW;
    localparam logic [IW-1:0] INF_MAX = {IW{1'b1}};
    localparam logic [CW-1:0] LD_CNT  = CW'(LD_LAT);
    localparam logic [CW-1:0] ALU_CNT = CW'(ALU_LAT);

    logic [NREGS*IW-1:0] inflight_flat;
    logic [NREGS*CW-1:0] cnt_flat;
    logic [NREGS-1:0]    busy;
    logic [NRD-1:0]      raw_hazard;
    logic [NRD-1:0]      fwd_hit;
    logic                overflow;
    logic                stall;
    logic                accept;
    logic                retire_err;
    logic [XLEN-1:0]     stall_cnt_reg;
    logic                err_reg;

    // x0 carries no state, so its slots are tied off
    assign inflight_flat[IW-1:0] = '0;
    assign cnt_flat[CW-1:0]      = '0;
    assign busy[0]               = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [IW-1:0] inflight_reg;
            logic [CW-1:0] cnt_reg;
            logic          acc_hit;
            logic          ret_hit;

            assign acc_hit = accept && (sb.issue_rd_i == AW'(gi));
            // a retire with nothing outstanding is dropped (flagged via err)
            assign ret_hit = sb.wb_valid_i && (sb.wb_rd_i == AW'(gi)) && (inflight_reg != '0);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    inflight_reg <= '0;
                    cnt_reg      <= '0;
                end else if (sb.rdy) begin
                    if (acc_hit)
                        cnt_reg <= sb.issue_is_load_i ? LD_CNT : ALU_CNT;
                    else if (cnt_reg != '0)
                        cnt_reg <= cnt_reg - 1'b1;

                    if (acc_hit && !ret_hit)
                        inflight_reg <= inflight_reg + 1'b1;
                    else if (!acc_hit && ret_hit)
                        inflight_reg <= inflight_reg - 1'b1;
                end
            end

            assign inflight_flat[gi*IW +: IW] = inflight_reg;
            assign cnt_flat[gi*CW +: CW]      = cnt_reg;
            assign busy[gi]                   = (inflight_reg != '0);
        end
    endgenerate

    always_comb begin
        logic [AW-1:0] a;
        a          = '0;
        raw_hazard = '0;
        fwd_hit    = '0;
        for (int k = 0; k < NRD; k++) begin
            a = sb.rs_addr_i[k*AW +: AW];
            if (sb.rs_read_i[k] && (a != '0) && busy[a]) begin
                if (cnt_flat[int'(a)*CW +: CW] != '0)
                    raw_hazard[k] = 1'b1;
                else
                    fwd_hit[k] = 1'b1;
            end
        end

        overflow = sb.issue_wreg_i && (sb.issue_rd_i != '0) &&
                   (inflight_flat[int'(sb.issue_rd_i)*IW +: IW] == INF_MAX);
        stall    = sb.issue_valid_i && sb.rdy && ((|raw_hazard) || overflow);
        accept   = sb.issue_valid_i && sb.rdy && !stall &&
                   sb.issue_wreg_i && (sb.issue_rd_i != '0);
        retire_err = sb.rdy && sb.wb_valid_i && (sb.wb_rd_i != '0) &&
                     (inflight_flat[int'(sb.wb_rd_i)*IW +: IW] == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (stall && (stall_cnt_reg != {XLEN{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (retire_err)
                err_reg <= 1'b1;
        end
    end

    assign sb.stall_o     = stall;
    assign sb.fwd_hit_o   = fwd_hit;
    assign sb.busy_o      = busy;
    assign sb.stall_cnt_o = stall_cnt_reg;
    assign sb.err_o       = err_reg;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed per-cycle vector table for the load-use,
// bypass, x0, overflow, retire and rdy cases, then randomized traffic vs a model.
module tb_id_scoreboard;
    localparam int XLEN  = 4;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_scoreboard_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) sb ();
    id_scoreboard #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       rdy;
        logic       valid;
        logic       wreg;
        logic       load;
        logic [4:0] rd;
        logic [1:0] rs_read;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic       wb_valid;
        logic [4:0] wb_rd;
        logic       exp_stall;
        logic [1:0] exp_fwd;
        logic [3:0] exp_scnt;
        logic       exp_err;
        logic [4:0] chk_reg;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input int rdy, valid, wreg, load, rd, rs_read, rs0, rs1,
                                 input int wb_valid, wb_rd, exp_stall, exp_fwd, exp_scnt,
                                 input int exp_err, chk_reg, exp_busy);
        vec_t v;
        v.rdy       = 1'(rdy);
        v.valid     = 1'(valid);
        v.wreg      = 1'(wreg);
        v.load      = 1'(load);
        v.rd        = 5'(rd);
        v.rs_read   = 2'(rs_read);
        v.rs0       = 5'(rs0);
        v.rs1       = 5'(rs1);
        v.wb_valid  = 1'(wb_valid);
        v.wb_rd     = 5'(wb_rd);
        v.exp_stall = 1'(exp_stall);
        v.exp_fwd   = 2'(exp_fwd);
        v.exp_scnt  = 4'(exp_scnt);
        v.exp_err   = 1'(exp_err);
        v.chk_reg   = 5'(chk_reg);
        v.exp_busy  = 1'(exp_busy);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sb.rdy             = v.rdy;
        sb.issue_valid_i   = v.valid;
        sb.issue_wreg_i    = v.wreg;
        sb.issue_rd_i      = v.rd;
        sb.issue_is_load_i = v.load;
        sb.rs_read_i       = v.rs_read;
        sb.rs_addr_i       = {v.rs1, v.rs0};
        sb.wb_valid_i      = v.wb_valid;
        sb.wb_rd_i         = v.wb_rd;
    endtask

    // inputs change just after a rising edge, outputs are sampled on the falling edge
    task automatic apply_row(input int i);
        vec_t v;
        v = tbl[i];
        drive(v);
        @(negedge clk);
        check($sformatf("row%0d stall", i), 32'(sb.stall_o), 32'(v.exp_stall));
        check($sformatf("row%0d fwd", i), 32'(sb.fwd_hit_o), 32'(v.exp_fwd));
        check($sformatf("row%0d stall_cnt", i), 32'(sb.stall_cnt_o), 32'(v.exp_scnt));
        check($sformatf("row%0d err", i), 32'(sb.err_o), 32'(v.exp_err));
        check($sformatf("row%0d busy[%0d]", i, v.chk_reg), 32'(sb.busy_o[v.chk_reg]), 32'(v.exp_busy));
        $display("row %0d: stall=%0b fwd=%b stall_cnt=%0d err=%0b busy[%0d]=%0b",
                 i, sb.stall_o, sb.fwd_hit_o, sb.stall_cnt_o, sb.err_o, v.chk_reg, sb.busy_o[v.chk_reg]);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // reference model: outstanding-write count and the active-cycle index at
    // which the newest write to each register becomes forwardable
    int  outst[NREGS];
    int  ready_at[NREGS];
    int  tick;
    bit  m_err;
    int  m_scnt;

    initial begin
        int seg1, seg2, seg3;
        vec_t idle;
        idle = mkv(1,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0);
        drive(idle);
        #12;
        check("reset stall", 32'(sb.stall_o), 0);
        check("reset busy", sb.busy_o, 0);
        check("reset stall_cnt", 32'(sb.stall_cnt_o), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // load-use, ALU bypass with retire, x0, inflight overflow
        tbl.push_back(mkv(1,1,1,1,5, 0,0,0, 0,0, 0,0,0,0, 5,0));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 1,0,0,0, 5,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 1,0,1,0, 5,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 0,1,2,0, 5,1));
        tbl.push_back(mkv(1,1,1,0,7, 0,0,0, 0,0, 0,0,2,0, 7,0));
        tbl.push_back(mkv(1,1,0,0,0, 2,0,7, 1,7, 0,2,2,0, 7,1));
        tbl.push_back(mkv(1,1,0,0,0, 2,0,7, 0,0, 0,0,2,0, 7,0));
        tbl.push_back(mkv(1,1,1,1,0, 0,0,0, 0,0, 0,0,2,0, 0,0));
        tbl.push_back(mkv(1,1,0,0,0, 3,0,0, 0,0, 0,0,2,0, 0,0));
        tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 0,0,2,0, 9,0));
        tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 0,0,2,0, 9,1));
        tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 0,0,2,0, 9,1));
        tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 1,0,2,0, 9,1));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0, 0,0, 0,0,3,0, 5,1));
        seg1 = tbl.size();
        // accept+retire on the same edge, then retire with nothing outstanding
        tbl.push_back(mkv(1,1,1,1,3, 0,0,0, 0,0, 0,0,0,0, 3,0));
        tbl.push_back(mkv(1,1,1,1,3, 0,0,0, 1,3, 0,0,0,0, 3,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,3,0, 0,0, 1,0,0,0, 3,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,3,0, 0,0, 1,0,1,0, 3,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,3,0, 1,3, 0,1,2,0, 3,1));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0, 1,3, 0,0,2,0, 3,0));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0, 0,0, 0,0,2,1, 3,0));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0, 0,0, 0,0,2,1, 3,0));
        seg2 = tbl.size();
        // rdy freeze during a load countdown, then stall-counter saturation
        tbl.push_back(mkv(1,1,1,1,5, 0,0,0, 0,0, 0,0,0,0, 5,0));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 1,0,0,0, 5,1));
        tbl.push_back(mkv(0,1,0,0,0, 1,5,0, 0,0, 0,0,1,0, 5,1));
        tbl.push_back(mkv(0,1,0,0,0, 1,5,0, 0,0, 0,0,1,0, 5,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 1,0,1,0, 5,1));
        tbl.push_back(mkv(1,1,0,0,0, 1,5,0, 0,0, 0,1,2,0, 5,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 0,0,2,0, 9,i > 0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mkv(1,1,1,0,9, 0,0,0, 0,0, 1,0,(2+i > 15) ? 15 : 2+i,0, 9,1));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0, 0,0, 0,0,15,0, 9,1));
        seg3 = tbl.size();

        for (int i = 0; i < seg1; i++) apply_row(i);

        // asynchronous reset mid-cycle with a stalling, bypassing instruction present
        drive(mkv(1,1,1,0,9, 1,5,0, 0,0, 0,0,0,0, 0,0));
        #2;
        check("pre-reset stall", 32'(sb.stall_o), 1);
        check("pre-reset fwd", 32'(sb.fwd_hit_o), 1);
        rst = 1'b0;
        #1;
        check("async reset stall", 32'(sb.stall_o), 0);
        check("async reset fwd", 32'(sb.fwd_hit_o), 0);
        check("async reset busy", sb.busy_o, 0);
        check("async reset stall_cnt", 32'(sb.stall_cnt_o), 0);
        $display("reset mid-cycle: stall=%0b fwd=%b busy=%h", sb.stall_o, sb.fwd_hit_o, sb.busy_o);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = seg1; i < seg2; i++) apply_row(i);
        pulse_reset();
        for (int i = seg2; i < seg3; i++) apply_row(i);

        // randomized traffic against the model
        pulse_reset();
        for (int r = 0; r < NREGS; r++) begin
            outst[r]    = 0;
            ready_at[r] = 0;
        end
        tick   = 0;
        m_err  = 1'b0;
        m_scnt = 0;
        for (int c = 0; c < 1500; c++) begin
            vec_t v;
            int   wr;
            bit   haz, ovf, acc;
            logic [1:0]  efwd;
            logic [31:0] ebusy;
            logic        estall;
            v = idle;
            v.rdy     = ($urandom_range(0, 9) != 0);
            v.valid   = ($urandom_range(0, 3) != 0);
            v.wreg    = 1'($urandom_range(0, 1));
            v.load    = 1'($urandom_range(0, 1));
            v.rd      = 5'($urandom_range(0, 7));
            v.rs_read = 2'($urandom_range(0, 3));
            v.rs0     = 5'($urandom_range(0, 7));
            v.rs1     = 5'($urandom_range(0, 7));
            wr = $urandom_range(1, 7);
            if (outst[wr] > 0 && $urandom_range(0, 2) == 0) begin
                v.wb_valid = 1'b1;
                v.wb_rd    = 5'(wr);
            end else if ($urandom_range(0, 99) == 0) begin
                v.wb_valid = 1'b1;
                v.wb_rd    = 5'($urandom_range(0, 7));
            end

            haz  = 1'b0;
            efwd = '0;
            for (int k = 0; k < 2; k++) begin
                int a;
                a = (k == 0) ? int'(v.rs0) : int'(v.rs1);
                if (v.rs_read[k] && a != 0 && outst[a] > 0) begin
                    if (ready_at[a] > tick) haz = 1'b1;
                    else efwd[k] = 1'b1;
                end
            end
            ovf    = v.wreg && v.rd != 0 && outst[v.rd] == 3;
            estall = v.valid && v.rdy && (haz || ovf);
            for (int r = 0; r < NREGS; r++) ebusy[r] = (outst[r] != 0);

            drive(v);
            @(negedge clk);
            check("rand stall", 32'(sb.stall_o), 32'(estall));
            check("rand fwd", 32'(sb.fwd_hit_o), 32'(efwd));
            check("rand busy", sb.busy_o, ebusy);
            check("rand stall_cnt", 32'(sb.stall_cnt_o), 32'(m_scnt));
            check("rand err", 32'(sb.err_o), 32'(m_err));
            $display("rand %0d: rdy=%0b stall=%0b fwd=%b busy=%h cnt=%0d err=%0b",
                     c, v.rdy, sb.stall_o, sb.fwd_hit_o, sb.busy_o, sb.stall_cnt_o, sb.err_o);

            if (v.rdy) begin
                acc = v.valid && !estall && v.wreg && v.rd != 0;
                if (v.wb_valid && v.wb_rd != 0) begin
                    if (outst[v.wb_rd] == 0) m_err = 1'b1;
                    else outst[v.wb_rd]--;
                end
                tick++;
                if (acc) begin
                    outst[v.rd]++;
                    ready_at[v.rd] = tick + (v.load ? 2 : 0);
                end
            end
            if (estall && m_scnt < 15) m_scnt++;
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
